imem_loader: RTL and testbench

- Boot-time initiator for the instruction-memory write port (im_write / im_addr / im_wdata) of the single-cycle MIPS core.
- Accepts a byte stream from a host link over a valid/ready interface, assembles big-endian 32-bit words, and issues one single-cycle write per word at sequential word addresses.
- Holds the CPU while loading and releases it when the image is complete.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host byte stream, imem write port and boot status of the instruction-memory loader.
// The loader takes the slave view; the host/bench takes the master view.
interface imem_loader_if;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        im_write;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, s_valid, s_data,
        input  s_ready, im_write, im_addr, im_wdata, cpu_hold, busy, done, error
    );

    modport slave (
        input  start, s_valid, s_data,
        output s_ready, im_write, im_addr, im_wdata, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: 4-byte big-endian count N, then N big-endian words written to imem at stepped addresses.
// Write one cycle after the last byte of a word, done two; s_ready drops during writes and after the load ends.
module imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [31:0] ADDR_STEP = 32'd1,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic          clk,
    input  logic          rstn,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERROR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_idx, byte_idx_nxt;
    logic [23:0] shift_q, shift_nxt;
    logic [31:0] word_n, word_n_nxt;
    logic [31:0] word_cnt, word_cnt_nxt;
    logic [31:0] idle_cnt, idle_nxt;

    logic        s_ready_q, s_ready_nxt;
    logic        im_write_q, im_write_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic        hold_q, hold_nxt;
    logic        busy_q, busy_nxt;
    logic        done_q, done_nxt;
    logic        error_q, error_nxt;

    logic        xfer;
    logic [31:0] byte_word;
    logic        idle_expired;

    assign xfer         = bus.s_valid && s_ready_q;
    assign byte_word    = {shift_q, bus.s_data};
    assign idle_expired = (TIMEOUT != 0) && (idle_cnt + 32'd1 == 32'(TIMEOUT));

    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        shift_nxt    = shift_q;
        word_n_nxt   = word_n;
        word_cnt_nxt = word_cnt;
        idle_nxt     = idle_cnt;
        im_write_nxt = 1'b0;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        hold_nxt     = hold_q;
        busy_nxt     = busy_q;
        done_nxt     = done_q;
        error_nxt    = error_q;

        case (state)
            IDLE, DONE, ERROR: begin
                // Status follows the terminal state one cycle later; a start overrides it.
                if (state == DONE) begin
                    done_nxt = 1'b1;
                    hold_nxt = 1'b0;
                    busy_nxt = 1'b0;
                end
                if (state == ERROR) begin
                    error_nxt = 1'b1;
                    hold_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
                if (bus.start) begin
                    state_nxt    = HDR;
                    byte_idx_nxt = 2'd0;
                    word_cnt_nxt = 32'd0;
                    idle_nxt     = 32'd0;
                    addr_nxt     = BASE_ADDR;
                    done_nxt     = 1'b0;
                    error_nxt    = 1'b0;
                    hold_nxt     = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    shift_nxt    = byte_word[23:0];
                    byte_idx_nxt = byte_idx + 2'd1;
                    idle_nxt     = 32'd0;
                    if (byte_idx == 2'd3) begin
                        word_n_nxt = byte_word;
                        if (byte_word == 32'd0)
                            state_nxt = DONE;
                        else if (byte_word > 32'(DEPTH))
                            state_nxt = ERROR;
                        else
                            state_nxt = DATA;
                    end
                end else if (byte_idx != 2'd0) begin
                    idle_nxt = idle_cnt + 32'd1;
                    if (idle_expired)
                        state_nxt = ERROR;
                end
            end
            DATA: begin
                if (xfer) begin
                    shift_nxt    = byte_word[23:0];
                    byte_idx_nxt = byte_idx + 2'd1;
                    idle_nxt     = 32'd0;
                    if (byte_idx == 2'd3) begin
                        wdata_nxt    = byte_word;
                        im_write_nxt = 1'b1;
                        state_nxt    = WRITE;
                    end
                end else begin
                    idle_nxt = idle_cnt + 32'd1;
                    if (idle_expired)
                        state_nxt = ERROR;
                end
            end
            WRITE: begin
                addr_nxt     = addr_q + ADDR_STEP;
                word_cnt_nxt = word_cnt + 32'd1;
                state_nxt    = (word_cnt + 32'd1 == word_n) ? DONE : DATA;
            end
            default: state_nxt = IDLE;
        endcase

        s_ready_nxt = (state_nxt == HDR) || (state_nxt == DATA);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            shift_q    <= 24'd0;
            word_n     <= 32'd0;
            word_cnt   <= 32'd0;
            idle_cnt   <= 32'd0;
            s_ready_q  <= 1'b0;
            im_write_q <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_idx   <= byte_idx_nxt;
            shift_q    <= shift_nxt;
            word_n     <= word_n_nxt;
            word_cnt   <= word_cnt_nxt;
            idle_cnt   <= idle_nxt;
            s_ready_q  <= s_ready_nxt;
            im_write_q <= im_write_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            hold_q     <= hold_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            error_q    <= error_nxt;
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.im_write = im_write_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign bus.cpu_hold = hold_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Two loaders (different base/step) share one byte stream; a scoreboard checks every imem write.
module tb_imem_loader;
    localparam logic [31:0] A_BASE = 32'h0;
    localparam logic [31:0] A_STEP = 32'd1;
    localparam logic [31:0] B_BASE = 32'h100;
    localparam logic [31:0] B_STEP = 32'd4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h0;

    int checks = 0;
    int errors = 0;
    wr_t qa[$];
    wr_t qb[$];
    logic [31:0] img [0:1023];

    always #5 clk = ~clk;

    imem_loader_if ifa ();
    imem_loader_if ifb ();

    assign ifa.start   = start;
    assign ifa.s_valid = s_valid;
    assign ifa.s_data  = s_data;
    assign ifb.start   = start;
    assign ifb.s_valid = s_valid;
    assign ifb.s_data  = s_data;

    imem_loader #(.DEPTH(1024), .BASE_ADDR(A_BASE), .ADDR_STEP(A_STEP), .TIMEOUT(16))
        dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
    imem_loader #(.DEPTH(1024), .BASE_ADDR(B_BASE), .ADDR_STEP(B_STEP), .TIMEOUT(16))
        dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: word i of an image lands at BASE + i*STEP.
    task automatic expect_word(input int idx, input logic [31:0] data);
        wr_t e;
        e.data = data;
        e.addr = A_BASE + 32'(idx) * A_STEP;
        qa.push_back(e);
        e.addr = B_BASE + 32'(idx) * B_STEP;
        qb.push_back(e);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (ifa.im_write === 1'b1) begin
            if (qa.size() == 0) check("unexpected_write_a", 32'(ifa.im_write), 32'd0);
            else begin
                e = qa.pop_front();
                check("write_addr_a", ifa.im_addr, e.addr);
                check("write_data_a", ifa.im_wdata, e.data);
            end
        end
        if (ifb.im_write === 1'b1) begin
            if (qb.size() == 0) check("unexpected_write_b", 32'(ifb.im_write), 32'd0);
            else begin
                e = qb.pop_front();
                check("write_addr_b", ifb.im_addr, e.addr);
                check("write_data_b", ifb.im_wdata, e.data);
            end
        end
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_data  = b;
        s_valid = 1'b1;
        n = 0;
        while (ifa.s_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        if (ifa.s_ready !== 1'b1) begin
            check("byte_accept_wait", 32'(ifa.s_ready), 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap, input int gap2, input bit is_data);
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (k == 2 && gap2 >= 0) ? gap2 : int'($urandom_range(maxgap, 0));
            send_byte(8'(w >> (24 - 8 * k)), g);
        end
        if (is_data) begin
            check("write_strobe", 32'(ifa.im_write), 32'd1);
            check("ready_low_in_write", 32'(ifa.s_ready), 32'd0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_done_clear", 32'(ifa.done), 32'd0);
        check("start_error_clear", 32'(ifa.error), 32'd0);
        check("start_hold", 32'(ifa.cpu_hold), 32'd1);
        check("start_busy", 32'(ifa.busy), 32'd1);
        check("start_ready", 32'(ifa.s_ready), 32'd1);
    endtask

    task automatic post_checks(input int n);
        @(posedge clk); #1;
        check("write_one_cycle", 32'(ifa.im_write), 32'd0);
        check("done_not_yet", 32'(ifa.done), 32'd0);
        @(posedge clk); #1;
        check("done", 32'(ifa.done), 32'd1);
        check("done_b", 32'(ifb.done), 32'd1);
        check("done_hold", 32'(ifa.cpu_hold), 32'd0);
        check("done_busy", 32'(ifa.busy), 32'd0);
        check("done_ready", 32'(ifa.s_ready), 32'd0);
        check("done_error", 32'(ifa.error), 32'd0);
        check("end_addr_a", ifa.im_addr, A_BASE + 32'(n) * A_STEP);
        check("end_addr_b", ifb.im_addr, B_BASE + 32'(n) * B_STEP);
    endtask

    task automatic run_load(input int n, input int maxgap, input int gap2);
        pulse_start();
        send_word(32'(n), maxgap, -1, 1'b0);
        for (int i = 0; i < n; i++) begin
            send_word(img[i], maxgap, gap2, 1'b1);
            expect_word(i, img[i]);
        end
        post_checks(n);
    endtask

    task automatic check_reset_values();
        check("rst_ready", 32'(ifa.s_ready), 32'd0);
        check("rst_write", 32'(ifa.im_write), 32'd0);
        check("rst_addr_a", ifa.im_addr, A_BASE);
        check("rst_addr_b", ifb.im_addr, B_BASE);
        check("rst_wdata", ifa.im_wdata, 32'd0);
        check("rst_hold", 32'(ifa.cpu_hold), 32'd1);
        check("rst_busy", 32'(ifa.busy), 32'd0);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_error", 32'(ifa.error), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", 32'(ifa.s_ready), 32'd0);

        // Basic load
        img[0] = 32'h2008_0005;
        img[1] = 32'hAC08_0000;
        run_load(2, 0, -1);

        // Restart from DONE; dut_b steps 0x100, 0x104, 0x108
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        run_load(3, 0, -1);

        // Empty image
        pulse_start();
        send_word(32'd0, 0, -1, 1'b0);
        check("empty_done_lag", 32'(ifa.done), 32'd0);
        @(posedge clk); #1;
        check("empty_done", 32'(ifa.done), 32'd1);
        check("empty_hold", 32'(ifa.cpu_hold), 32'd0);
        check("empty_addr_a", ifa.im_addr, A_BASE);
        check("empty_addr_b", ifb.im_addr, B_BASE);

        // Oversize image
        pulse_start();
        send_word(32'd1025, 0, -1, 1'b0);
        @(posedge clk); #1;
        check("over_error", 32'(ifa.error), 32'd1);
        check("over_hold", 32'(ifa.cpu_hold), 32'd1);
        check("over_busy", 32'(ifa.busy), 32'd0);
        check("over_done", 32'(ifa.done), 32'd0);
        s_valid = 1'b1; s_data = 8'h5A;
        repeat (3) begin
            @(posedge clk); #1;
            check("over_ready", 32'(ifa.s_ready), 32'd0);
        end
        s_valid = 1'b0;

        // Gaps below the timeout
        img[0] = $urandom;
        run_load(1, 0, 10);
        img[0] = $urandom;
        run_load(1, 0, 15);

        // Gap equal to the timeout
        w = $urandom;
        pulse_start();
        send_word(32'd1, 0, -1, 1'b0);
        send_byte(w[31:24], 0);
        send_byte(w[23:16], 0);
        repeat (15) begin @(posedge clk); #1; end
        check("gap15_still_ready", 32'(ifa.s_ready), 32'd1);
        @(posedge clk); #1;
        check("timeout_ready", 32'(ifa.s_ready), 32'd0);
        @(posedge clk); #1;
        check("timeout_error", 32'(ifa.error), 32'd1);
        check("timeout_hold", 32'(ifa.cpu_hold), 32'd1);
        check("timeout_done", 32'(ifa.done), 32'd0);
        s_valid = 1'b1; s_data = w[15:8];
        repeat (4) begin @(posedge clk); #1; end
        check("timeout_ready_hold", 32'(ifa.s_ready), 32'd0);
        s_valid = 1'b0;

        // Start pulse mid-DATA is ignored
        img[0] = $urandom;
        img[1] = $urandom;
        pulse_start();
        send_word(32'd2, 0, -1, 1'b0);
        send_byte(img[0][31:24], 0);
        send_byte(img[0][23:16], 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_start_busy", 32'(ifa.busy), 32'd1);
        check("mid_start_ready", 32'(ifa.s_ready), 32'd1);
        send_byte(img[0][15:8], 0);
        send_byte(img[0][7:0], 0);
        check("mid_start_write", 32'(ifa.im_write), 32'd1);
        expect_word(0, img[0]);
        send_word(img[1], 0, -1, 1'b1);
        expect_word(1, img[1]);
        post_checks(2);

        // Reset mid-DATA, asserted together with start
        img[0] = $urandom;
        pulse_start();
        send_word(32'd2, 0, -1, 1'b0);
        send_byte(img[0][31:24], 0);
        send_byte(img[0][23:16], 0);
        rstn = 1'b0;
        start = 1'b1;
        s_valid = 1'b1; s_data = img[0][15:8];
        @(posedge clk); #1;
        start = 1'b0;
        check_reset_values();
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("post_rst_ready", 32'(ifa.s_ready), 32'd0);
        end
        s_valid = 1'b0;

        // Random images with random byte gaps
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_load(n, 14, -1);
        end

        // Exactly DEPTH words is accepted
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        run_load(1024, 0, -1);

        repeat (3) @(posedge clk);
        #1;
        check("pending_a", 32'(qa.size()), 32'd0);
        check("pending_b", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
